// File: rtl/seq_detect_param_if.sv
// Serial stream, configuration and result signals of the parametrised sequence detector.
// The master side drives the stream and configuration; the slave side is the detector.
interface seq_detect_param_if #(
  parameter int MAX_W = 8,
  parameter int CNT_W = 8
);
  localparam int LEN_W = $clog2(MAX_W + 1);

  logic             en_i;
  logic             cfg_load_i;
  logic [MAX_W-1:0] cfg_pattern_i;
  logic [LEN_W-1:0] cfg_len_i;
  logic             cfg_overlap_i;
  logic             in_i;
  logic             in_valid_i;
  logic             cnt_clr_i;
  logic             out_o;
  logic             busy_o;
  logic [CNT_W-1:0] match_cnt_o;

  modport master (
    output en_i, cfg_load_i, cfg_pattern_i, cfg_len_i, cfg_overlap_i,
           in_i, in_valid_i, cnt_clr_i,
    input  out_o, busy_o, match_cnt_o
  );

  modport slave (
    input  en_i, cfg_load_i, cfg_pattern_i, cfg_len_i, cfg_overlap_i,
           in_i, in_valid_i, cnt_clr_i,
    output out_o, busy_o, match_cnt_o
  );
endinterface

// File: rtl/seq_detect_param.sv
// Runtime-programmable serial pattern detector with overlap control and a registered match pulse.
// Define SEQ_DET_COUNT_EN to add the saturating match counter (match_cnt/cnt_clr).
module seq_detect_param #(
  parameter int               MAX_W       = 8,
  parameter logic [MAX_W-1:0] DEF_PATTERN = 8'h0B,
  parameter int               DEF_LEN     = 4,
  parameter int               CNT_W       = 8
) (
  input logic               clk,
  input logic               rst_n,
  seq_detect_param_if.slave bus
);

  localparam int LEN_W = $clog2(MAX_W + 1);
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_W);
  localparam logic [LEN_W-1:0] RST_LEN = LEN_W'(DEF_LEN);

  typedef enum logic [1:0] {IDLE, HUNT, MATCH} state_t;

  state_t           state_q;
  logic [MAX_W-1:0] hist_q, hist_d;
  logic [MAX_W-1:0] pattern_q;
  logic [MAX_W-1:0] len_mask;
  logic [LEN_W-1:0] len_q, fill_q, fill_d, cfg_len_clamped;
  logic             overlap_q;
  logic             out_q;
  logic             match;

  always_comb begin
    hist_d   = {hist_q[MAX_W-2:0], bus.in_i};
    fill_d   = (fill_q >= len_q) ? len_q : fill_q + LEN_W'(1);
    len_mask = '0;
    for (int i = 0; i < MAX_W; i++) begin
      len_mask[i] = (i < int'(len_q));
    end
    cfg_len_clamped = ((bus.cfg_len_i == '0) || (bus.cfg_len_i > MAX_LEN)) ? MAX_LEN : bus.cfg_len_i;
    // A bit dropped by cfg_load or a disabled detector can never complete a match
    match = bus.en_i && !bus.cfg_load_i && bus.in_valid_i && (fill_d == len_q) &&
            (((hist_d ^ pattern_q) & len_mask) == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      hist_q    <= '0;
      fill_q    <= '0;
      pattern_q <= DEF_PATTERN;
      len_q     <= RST_LEN;
      overlap_q <= 1'b1;
      out_q     <= 1'b0;
    end else begin
      if (bus.cfg_load_i) begin
        pattern_q <= bus.cfg_pattern_i;
        len_q     <= cfg_len_clamped;
        overlap_q <= bus.cfg_overlap_i;
      end
      if (!bus.en_i || bus.cfg_load_i) begin
        state_q <= IDLE;
        hist_q  <= '0;
        fill_q  <= '0;
        out_q   <= 1'b0;
      end else if (bus.in_valid_i) begin
        hist_q <= hist_d;
        out_q  <= match;
        if (match) begin
          state_q <= MATCH;
          // Non-overlapping mode demands len fresh bits before the next match
          fill_q  <= overlap_q ? fill_d : '0;
        end else begin
          state_q <= HUNT;
          fill_q  <= fill_d;
        end
      end else begin
        out_q <= 1'b0;
        if (state_q == MATCH) begin
          state_q <= HUNT;
        end
      end
    end
  end

  assign bus.out_o  = out_q;
  assign bus.busy_o = (state_q != IDLE);

`ifdef SEQ_DET_COUNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (bus.cnt_clr_i) begin
      cnt_q <= '0;
    end else if (match && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.match_cnt_o = cnt_q;
`else
  assign bus.match_cnt_o = '0;
`endif

endmodule
